reg_bank_reader: RTL and testbench

Readback block for a bank of one-bit write-enabled storage registers. On a request it snapshots the bank's parallel outputs in a single cycle and streams the snapshot out one bit per transfer over a valid/ready serial interface, with a last-bit marker and a completion pulse. It sits beside the register bank, on the opposite side from the write path, and lets a debug or scan consumer read the stored state without disturbing writes.

---
 rtl/reg_bank_reader.sv | 97 +++++++++
 tb/tb_reg_bank_reader.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/reg_bank_reader.sv
// Readback engine for a bank of one-bit registers: snapshots the bank on request
// and streams the frozen copy out one bit per valid/ready transfer.
module reg_bank_reader #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [WIDTH-1:0] bits_in,
    input  logic             ready,
    output logic             out,
    output logic             valid,
    output logic             last,
    output logic             busy,
    output logic             done
);

    localparam int             CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;

    logic             in_shift;
    logic             at_last;
    logic [CW-1:0]    bit_idx;
    logic [WIDTH-1:0] shifted;

    assign in_shift = (state_q == SHIFT);
    assign at_last  = (cnt_q == LAST_CNT);

    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    shadow_d = bits_in;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (ready) begin
                    if (at_last) begin
                        // Wrap to zero so the counter never holds WIDTH.
                        cnt_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    // Outputs decode registered state only; ready and req never reach them.
    assign bit_idx = MSB_FIRST ? (LAST_CNT - cnt_q) : cnt_q;
    assign shifted = shadow_q >> bit_idx;

    assign out   = in_shift & shifted[0];
    assign valid = in_shift;
    assign busy  = in_shift;
    assign last  = in_shift & at_last;
    assign done  = done_q;

endmodule

// File: tb/tb_reg_bank_reader.sv
// Directed bench for reg_bank_reader: LSB/MSB order, backpressure, frozen
// snapshot, mid-readback reset and the single-bit configuration.
module tb_reg_bank_reader;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       req   = 1'b0;
    logic       ready = 1'b0;
    logic [3:0] bits  = 4'b0000;
    logic       sel   = 1'b0;

    logic a_out, a_valid, a_last, a_busy, a_done;
    logic b_out, b_valid, b_last, b_busy, b_done;
    logic c_out, c_valid, c_last, c_busy, c_done;
    logic o_out, o_valid, o_last, o_busy, o_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_bank_reader #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .req(req), .bits_in(bits), .ready(ready),
        .out(a_out), .valid(a_valid), .last(a_last), .busy(a_busy), .done(a_done)
    );

    reg_bank_reader #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset(reset), .req(req), .bits_in(bits), .ready(ready),
        .out(b_out), .valid(b_valid), .last(b_last), .busy(b_busy), .done(b_done)
    );

    reg_bank_reader #(.WIDTH(1), .MSB_FIRST(1'b0)) dut_one (
        .clk(clk), .reset(reset), .req(req), .bits_in(bits[0:0]), .ready(ready),
        .out(c_out), .valid(c_valid), .last(c_last), .busy(c_busy), .done(c_done)
    );

    assign o_out   = sel ? b_out   : a_out;
    assign o_valid = sel ? b_valid : a_valid;
    assign o_last  = sel ? b_last  : a_last;
    assign o_busy  = sel ? b_busy  : a_busy;
    assign o_done  = sel ? b_done  : a_done;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // exp_seq[k] is the k-th bit expected on out; rdy_pat[i] is ready in cycle i.
    // mangle clears bits_in right after capture and pulses req mid-stream.
    task automatic run_read(input logic [3:0] snap, input logic [3:0] exp_seq,
                            input logic [15:0] rdy_pat, input int n_pat, input bit mangle);
        int k = 0;
        int i = 0;
        @(negedge clk);
        bits  = snap;
        req   = 1'b1;
        ready = 1'b1;
        while (k < 4 && i < 40) begin
            @(negedge clk);
            req = mangle && (i == 1);
            if (mangle && i == 0) bits = 4'b0000;
            check("valid", 8'(o_valid), 8'd1);
            check("busy",  8'(o_busy),  8'd1);
            check("out",   8'(o_out),   8'(exp_seq[k]));
            check("last",  8'(o_last),  8'(k == 3));
            check("done_in_shift", 8'(o_done), 8'd0);
            ready = (i < n_pat) ? rdy_pat[i] : 1'b1;
            if (ready) k++;
            i++;
        end
        check("xfer_count", 8'(k), 8'd4);
        @(negedge clk);
        req = 1'b0;
        check("done_pulse", 8'(o_done),  8'd1);
        check("done_valid", 8'(o_valid), 8'd0);
        check("done_busy",  8'(o_busy),  8'd0);
        check("done_last",  8'(o_last),  8'd0);
        @(negedge clk);
        check("done_drop",    8'(o_done),  8'd0);
        check("no_restart",   8'(o_valid), 8'd0);
    endtask

    initial begin
        #12;
        check("rst_out",   8'(a_out),   8'd0);
        check("rst_valid", 8'(a_valid), 8'd0);
        check("rst_last",  8'(a_last),  8'd0);
        check("rst_busy",  8'(a_busy),  8'd0);
        check("rst_done",  8'(a_done),  8'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // LSB first, ready held high: 1,1,0,1
        sel = 1'b0;
        run_read(4'b1011, 4'b1011, 16'hFFFF, 0, 1'b0);

        // MSB first, same snapshot: 1,0,1,1
        sel = 1'b1;
        run_read(4'b1011, 4'b1101, 16'hFFFF, 0, 1'b0);

        // Backpressure: ready 1,0,0,1,0,1,1
        sel = 1'b0;
        run_read(4'b1011, 4'b1011, 16'h0069, 7, 1'b0);

        // Snapshot frozen, mid-stream req ignored
        run_read(4'b1011, 4'b1011, 16'hFFFF, 0, 1'b1);

        // Reset after the second transfer
        @(negedge clk);
        bits  = 4'b1011;
        req   = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        req = 1'b0;
        check("pre_rst_bit0", 8'(a_out), 8'd1);
        @(negedge clk);
        check("pre_rst_bit1", 8'(a_out), 8'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort_out",   8'(a_out),   8'd0);
        check("abort_valid", 8'(a_valid), 8'd0);
        check("abort_last",  8'(a_last),  8'd0);
        check("abort_busy",  8'(a_busy),  8'd0);
        check("abort_done",  8'(a_done),  8'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done",  8'(a_done),  8'd0);
            check("abort_no_valid", 8'(a_valid), 8'd0);
        end
        run_read(4'b0110, 4'b0110, 16'hFFFF, 0, 1'b0);

        // Single-bit bank
        @(negedge clk);
        bits  = 4'b0001;
        req   = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        req = 1'b0;
        check("w1_valid", 8'(c_valid), 8'd1);
        check("w1_last",  8'(c_last),  8'd1);
        check("w1_out",   8'(c_out),   8'd1);
        check("w1_done0", 8'(c_done),  8'd0);
        @(negedge clk);
        check("w1_done",  8'(c_done),  8'd1);
        check("w1_idle",  8'(c_valid), 8'd0);
        @(negedge clk);
        check("w1_drop",  8'(c_done),  8'd0);
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
